// File: rtl/adc_emu_pkg.sv
// Shared types and constants for the serial ADC emulator.
package adc_emu_pkg;

    localparam int unsigned DWIDTH_DEF = 18;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_READY   = 2'd2,
        ST_SHIFT   = 2'd3
    } state_e;

    localparam logic [1:0] MODE_EXT   = 2'd0;
    localparam logic [1:0] MODE_RAMP  = 2'd1;
    localparam logic [1:0] MODE_ALT   = 2'd2;
    localparam logic [1:0] MODE_CONST = 2'd3;

    localparam logic [17:0] PAT_ALT_A = 18'h2AAAA;
    localparam logic [17:0] PAT_ALT_B = 18'h15555;
    localparam logic [17:0] PAT_CONST = 18'h3FFFF;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for one asynchronous input with registered rise/fall detect.
module sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              rise_q;
    logic              fall_q;

    // level_o is the flop that the edge pulses are computed against, so level and edges stay aligned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= (sync_q << 1) | STAGES'(d_i);
            prev_q <= sync_q[STAGES-1];
            rise_q <= sync_q[STAGES-1] & ~prev_q;
            fall_q <= ~sync_q[STAGES-1] & prev_q;
        end
    end

    assign level_o = prev_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/adc_serial_emu.sv
// Behavioural emulator of a busy/serial-readout ADC: conversion timing, sample
// sources, MSB-first shift-out and a sticky overrun/read error flag.
module adc_serial_emu
    import adc_emu_pkg::*;
#(
    parameter int unsigned BUSY_CYCLES = 160,
    parameter int unsigned DWIDTH      = DWIDTH_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              ADCNVST,
    input  logic              ADCS,
    input  logic              ADSCLK,
    input  logic [1:0]        MODE,
    input  logic [DWIDTH-1:0] SAMPLE_IN,
    output logic              ADBUSY,
    output logic              ADSDOUT,
    output logic              ADRDERR,
    output logic [15:0]       CONV_CNT
);

    localparam int unsigned CW = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
    localparam int unsigned PW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
    localparam logic [PW-1:0] PTR_MSB = PW'(DWIDTH - 1);

    logic cnvst_level, cnvst_rise, cnvst_fall;
    logic cs_level, cs_rise, cs_fall;
    logic sclk_level, sclk_rise, sclk_fall;
    logic unused_edges;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cnvst (
        .clk(CLK), .rst_n(RSTN), .d_i(ADCNVST),
        .level_o(cnvst_level), .rise_o(cnvst_rise), .fall_o(cnvst_fall)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(CLK), .rst_n(RSTN), .d_i(ADCS),
        .level_o(cs_level), .rise_o(cs_rise), .fall_o(cs_fall)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(CLK), .rst_n(RSTN), .d_i(ADSCLK),
        .level_o(sclk_level), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    assign unused_edges = ^{cnvst_level, cnvst_rise, cs_fall, sclk_level, sclk_rise};

    state_e            state_q, state_d;
    logic              busy_q, busy_d;
    logic              sdout_q, sdout_d;
    logic              err_q, err_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [DWIDTH-1:0] ramp_q, ramp_d;
    logic              alt_q, alt_d;
    logic [DWIDTH-1:0] data_q, data_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     bcnt_q, bcnt_d;
    logic [DWIDTH-1:0] sample_c;

    always_comb begin
        case (MODE)
            MODE_EXT:   sample_c = SAMPLE_IN;
            MODE_RAMP:  sample_c = ramp_q;
            MODE_ALT:   sample_c = alt_q ? DWIDTH'(PAT_ALT_B) : DWIDTH'(PAT_ALT_A);
            MODE_CONST: sample_c = DWIDTH'(PAT_CONST);
            default:    sample_c = SAMPLE_IN;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            sdout_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            ramp_q  <= '0;
            alt_q   <= 1'b0;
            data_q  <= '0;
            ptr_q   <= PTR_MSB;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            sdout_q <= sdout_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            ramp_q  <= ramp_d;
            alt_q   <= alt_d;
            data_q  <= data_d;
            ptr_q   <= ptr_d;
            bcnt_q  <= bcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        sdout_d = (state_q == ST_SHIFT) ? sdout_q : 1'b0;
        err_d   = err_q;
        cnt_d   = cnt_q;
        ramp_d  = ramp_q;
        alt_d   = alt_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        bcnt_d  = bcnt_q;

        case (state_q)
            ST_CONVERT: begin
                if (bcnt_q == '0) begin
                    state_d = ST_READY;
                    busy_d  = 1'b0;
                end else begin
                    bcnt_d = bcnt_q - CW'(1);
                end
            end
            ST_READY: begin
                if (!cs_level) begin
                    state_d = ST_SHIFT;
                    ptr_d   = PTR_MSB;
                    sdout_d = data_q[PTR_MSB];
                end
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    state_d = ST_READY;
                    ptr_d   = PTR_MSB;
                    sdout_d = 1'b0;
                end else if (sclk_fall && !cs_level) begin
                    if (ptr_q == '0) begin
                        state_d = ST_IDLE;
                        sdout_d = 1'b0;
                        err_d   = 1'b0;
                    end else begin
                        ptr_d   = ptr_q - PW'(1);
                        sdout_d = data_q[ptr_q - PW'(1)];
                    end
                end
            end
            default: ;
        endcase

        // Conversion start overrides any serial activity decided above
        if (cnvst_fall) begin
            if (state_q == ST_CONVERT) begin
                err_d = 1'b1;
            end else begin
                state_d = ST_CONVERT;
                busy_d  = 1'b1;
                bcnt_d  = CW'(BUSY_CYCLES - 1);
                data_d  = sample_c;
                cnt_d   = cnt_q + 16'd1;
                ramp_d  = ramp_q + DWIDTH'(1);
                alt_d   = ~alt_q;
                ptr_d   = PTR_MSB;
                sdout_d = 1'b0;
                if (state_q != ST_IDLE) begin
                    err_d = 1'b1;
                end
            end
        end
    end

    assign ADBUSY   = busy_q;
    assign ADSDOUT  = sdout_q;
    assign ADRDERR  = err_q;
    assign CONV_CNT = cnt_q;

endmodule
